// File: rtl/cache_ctrl_pkg.sv
// Shared types and geometry for the direct-mapped write-back cache controller.
package cache_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WB     = 2'd1,
    REFILL = 2'd2
  } state_e;

  localparam int unsigned LINE_WORDS = 8;
  localparam int unsigned NUM_LINES  = 4;
  localparam int unsigned OFFSET_LSB = 2;
  localparam int unsigned INDEX_LSB  = 5;
  localparam int unsigned TAG_LSB    = 7;
  localparam int unsigned IDX_W      = $clog2(NUM_LINES);
  localparam int unsigned OFF_W      = $clog2(LINE_WORDS);

endpackage

// File: rtl/cache_store.sv
// Line data, tags and valid/dirty bits with write ports and combinational read-out.
module cache_store
  import cache_ctrl_pkg::*;
#(
  parameter int unsigned TAG_W = 25
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        i_word_we,
  input  logic [IDX_W-1:0]                            i_word_idx,
  input  logic [OFF_W-1:0]                            i_word_off,
  input  logic [31:0]                                 i_word_data,
  input  logic                                        i_beat_we,
  input  logic [IDX_W-1:0]                            i_beat_idx,
  input  logic [OFF_W-1:0]                            i_beat_off,
  input  logic [31:0]                                 i_beat_data,
  input  logic                                        i_fill,
  input  logic [IDX_W-1:0]                            i_fill_idx,
  input  logic [TAG_W-1:0]                            i_fill_tag,
  input  logic                                        i_clean,
  input  logic [IDX_W-1:0]                            i_clean_idx,
  output logic [NUM_LINES-1:0][LINE_WORDS-1:0][31:0] o_lines,
  output logic [NUM_LINES-1:0][TAG_W-1:0]            o_tags,
  output logic [NUM_LINES-1:0]                        o_valid,
  output logic [NUM_LINES-1:0]                        o_dirty
);

  logic [NUM_LINES-1:0][LINE_WORDS-1:0][31:0] r_data;
  logic [NUM_LINES-1:0][TAG_W-1:0]            r_tag;
  logic [NUM_LINES-1:0]                        r_valid;
  logic [NUM_LINES-1:0]                        r_dirty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_tag   <= '0;
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      if (i_word_we) begin
        r_data[i_word_idx][i_word_off] <= i_word_data;
        r_dirty[i_word_idx]            <= 1'b1;
      end
      if (i_beat_we) begin
        r_data[i_beat_idx][i_beat_off] <= i_beat_data;
      end
      if (i_fill) begin
        r_tag[i_fill_idx]   <= i_fill_tag;
        r_valid[i_fill_idx] <= 1'b1;
        r_dirty[i_fill_idx] <= 1'b0;
      end
      if (i_clean) begin
        r_dirty[i_clean_idx] <= 1'b0;
      end
    end
  end

  assign o_lines = r_data;
  assign o_tags  = r_tag;
  assign o_valid = r_valid;
  assign o_dirty = r_dirty;

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped write-back/write-allocate cache controller: hit path, writeback and refill FSM.
module cache_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [255:0]      cache0,
  output logic [255:0]      cache1,
  output logic [255:0]      cache2,
  output logic [255:0]      cache3,
  output logic [3:0]        valid,
  output logic [3:0]        dirty
);

  localparam int unsigned TAG_W = ADDR_W - TAG_LSB;

  state_e              r_state, w_state_d;
  logic [OFF_W-1:0]    r_beat, w_beat_d;
  logic [ADDR_W-1:0]   r_miss_addr, w_miss_d;

  logic [NUM_LINES-1:0][LINE_WORDS-1:0][31:0] w_lines;
  logic [NUM_LINES-1:0][TAG_W-1:0]            w_tags;
  logic [NUM_LINES-1:0]                        w_valid, w_dirty;

  logic [IDX_W-1:0] w_idx, w_m_idx;
  logic [OFF_W-1:0] w_off;
  logic [TAG_W-1:0] w_tag, w_m_tag;
  logic             w_hit;
  logic             w_word_we, w_beat_we, w_fill, w_clean;
  logic             w_unused;

  assign w_idx   = cpu_addr[INDEX_LSB +: IDX_W];
  assign w_off   = cpu_addr[OFFSET_LSB +: OFF_W];
  assign w_tag   = cpu_addr[ADDR_W-1:TAG_LSB];
  assign w_m_idx = r_miss_addr[INDEX_LSB +: IDX_W];
  assign w_m_tag = r_miss_addr[ADDR_W-1:TAG_LSB];
  assign w_hit   = cpu_req & w_valid[w_idx] & (w_tags[w_idx] == w_tag);
  // Byte lane and offset bits of the latched miss are superseded by the beat counter.
  assign w_unused = ^{cpu_addr[1:0], r_miss_addr[INDEX_LSB-1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_beat      <= '0;
      r_miss_addr <= '0;
    end else begin
      r_state     <= w_state_d;
      r_beat      <= w_beat_d;
      r_miss_addr <= w_miss_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_beat_d  = r_beat;
    w_miss_d  = r_miss_addr;
    cpu_ready = 1'b0;
    cpu_rdata = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    w_word_we = 1'b0;
    w_beat_we = 1'b0;
    w_fill    = 1'b0;
    w_clean   = 1'b0;
    case (r_state)
      IDLE: begin
        cpu_rdata = w_lines[w_idx][w_off];
        if (cpu_req) begin
          if (w_hit) begin
            cpu_ready = 1'b1;
            w_word_we = cpu_we;
          end else begin
            w_miss_d  = cpu_addr;
            w_beat_d  = '0;
            w_state_d = (w_valid[w_idx] & w_dirty[w_idx]) ? WB : REFILL;
          end
        end
      end
      WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {w_tags[w_m_idx], w_m_idx, r_beat, 2'b00};
        mem_wdata = w_lines[w_m_idx][r_beat];
        if (mem_ack) begin
          w_beat_d = r_beat + 1'b1;
          if (r_beat == OFF_W'(LINE_WORDS - 1)) begin
            w_clean   = 1'b1;
            w_state_d = REFILL;
          end
        end
      end
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {w_m_tag, w_m_idx, r_beat, 2'b00};
        if (mem_ack) begin
          w_beat_we = 1'b1;
          w_beat_d  = r_beat + 1'b1;
          if (r_beat == OFF_W'(LINE_WORDS - 1)) begin
            w_fill    = 1'b1;
            w_state_d = IDLE;
          end
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  cache_store #(
    .TAG_W(TAG_W)
  ) u_store (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_word_we   (w_word_we),
    .i_word_idx  (w_idx),
    .i_word_off  (w_off),
    .i_word_data (cpu_wdata),
    .i_beat_we   (w_beat_we),
    .i_beat_idx  (w_m_idx),
    .i_beat_off  (r_beat),
    .i_beat_data (mem_rdata),
    .i_fill      (w_fill),
    .i_fill_idx  (w_m_idx),
    .i_fill_tag  (w_m_tag),
    .i_clean     (w_clean),
    .i_clean_idx (w_m_idx),
    .o_lines     (w_lines),
    .o_tags      (w_tags),
    .o_valid     (w_valid),
    .o_dirty     (w_dirty)
  );

  assign cache0 = w_lines[0];
  assign cache1 = w_lines[1];
  assign cache2 = w_lines[2];
  assign cache3 = w_lines[3];
  assign valid  = w_valid;
  assign dirty  = w_dirty;

endmodule

// File: tb/tb_cache_ctrl.sv
// Scoreboard bench for cache_ctrl: expected CPU responses and memory beats are queued by the
// stimulus and popped by monitors when the DUT presents them.
module tb_cache_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cpu_req, cpu_we;
  logic [31:0]  cpu_addr, cpu_wdata, cpu_rdata;
  logic         cpu_ready;
  logic         mem_req, mem_we;
  logic [31:0]  mem_addr, mem_wdata;
  logic [31:0]  mem_rdata;
  logic         mem_ack;
  logic [255:0] cache0, cache1, cache2, cache3;
  logic [3:0]   valid, dirty;

  always #5 clk = ~clk;

  cache_ctrl #(
    .ADDR_W(32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .cache0    (cache0),
    .cache1    (cache1),
    .cache2    (cache2),
    .cache3    (cache3),
    .valid     (valid),
    .dirty     (dirty)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } beat_t;

  typedef struct {
    logic        we;
    logic [31:0] rdata;
  } resp_t;

  beat_t mem_q[$];
  resp_t cpu_q[$];
  int    total = 0;
  int    bad = 0;
  int    ack_delay = 0;
  bit    mem_chk = 1'b1;

  // Backing memory contents: 0x100 per 128-byte block number plus word offset.
  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return ((32'(a[9:7]) + 32'd1) << 8) + 32'(a[4:2]);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_refill(input logic [31:0] base);
    for (int i = 0; i < 8; i++) mem_q.push_back('{1'b0, base + 32'(4 * i), 32'h0});
  endtask

  task automatic cpu_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] exp_rd, input int exp_cyc, input string name);
    int cyc;
    bit done;
    cyc  = 0;
    done = 1'b0;
    cpu_q.push_back('{we, exp_rd});
    @(posedge clk);
    #1;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wd;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (cpu_ready) done = 1'b1;
    end
    check(name, 32'(cyc), 32'(exp_cyc));
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
  endtask

  // Memory responder and beat monitor.
  initial begin
    int          wcnt;
    logic [31:0] first_addr;
    beat_t       e;
    wcnt       = 0;
    first_addr = '0;
    mem_ack    = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (mem_ack) wcnt = 0;
      mem_ack = 1'b0;
      if (mem_req) begin
        if (wcnt == 0) first_addr = mem_addr;
        if (wcnt >= ack_delay) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_model(mem_addr);
          if (mem_chk) begin
            if (ack_delay > 0) check("mem_addr_stable", mem_addr, first_addr);
            if (mem_q.size() == 0) begin
              total++;
              bad++;
              $display("FAIL unexpected_beat: got addr %h expected no beat", mem_addr);
            end else begin
              e = mem_q.pop_front();
              check("mem_we", {31'b0, mem_we}, {31'b0, e.we});
              check("mem_addr", mem_addr, e.addr);
              if (e.we) check("mem_wdata", mem_wdata, e.wdata);
            end
          end
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // CPU response monitor.
  initial begin
    resp_t r;
    forever begin
      @(negedge clk);
      if (cpu_ready) begin
        if (cpu_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ready: got ready at addr %h expected none", cpu_addr);
        end else begin
          r = cpu_q.pop_front();
          if (!r.we) check("cpu_rdata", cpu_rdata, r.rdata);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit found;
    logic [31:0] wb_words [8];
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_dirty", 32'(dirty), 32'h0);
    check("rst_mem_req", 32'(mem_req), 32'h0);
    check("rst_cpu_ready", 32'(cpu_ready), 32'h0);
    check("rst_cache2_w0", cache2[31:0], 32'h0);
    rst_n = 1'b1;

    // Cold read: clean miss, refill only
    push_refill(32'h40);
    cpu_access(1'b0, 32'h40, 32'h0, 32'h100, 10, "lat_cold_read");
    check("cold_valid", 32'(valid), 32'h4);
    check("cold_dirty", 32'(dirty), 32'h0);

    cpu_access(1'b0, 32'h4C, 32'h0, 32'h103, 1, "lat_read_hit");
    cpu_access(1'b1, 32'h44, 32'hDEADBEEF, 32'h0, 1, "lat_write_hit");
    check("wr_dirty", 32'(dirty), 32'h4);
    check("wr_cache2_w1", cache2[63:32], 32'hDEADBEEF);

    // Dirty miss with 3 wait cycles per beat
    ack_delay   = 3;
    wb_words[0] = 32'h100;
    wb_words[1] = 32'hDEADBEEF;
    for (int i = 2; i < 8; i++) wb_words[i] = 32'h100 + 32'(i);
    for (int i = 0; i < 8; i++) mem_q.push_back('{1'b1, 32'h40 + 32'(4 * i), wb_words[i]});
    push_refill(32'hC0);
    cpu_access(1'b0, 32'hC0, 32'h0, 32'h200, 66, "lat_dirty_miss");
    check("dm_dirty", 32'(dirty), 32'h0);
    check("dm_valid", 32'(valid), 32'h4);
    check("dm_cache2_w0", cache2[31:0], 32'h200);
    check("dm_cache2_w7", cache2[255:224], 32'h207);
    ack_delay = 0;
    cpu_access(1'b0, 32'hC4, 32'h0, 32'h201, 1, "lat_hit_new_tag");

    // Write miss: allocate then merge the store
    push_refill(32'h0);
    cpu_access(1'b1, 32'h08, 32'h12345678, 32'h0, 10, "lat_write_miss");
    check("wm_valid", 32'(valid), 32'h5);
    check("wm_dirty", 32'(dirty), 32'h1);
    check("wm_cache0_w2", cache0[95:64], 32'h12345678);
    check("wm_cache0_w0", cache0[31:0], 32'h100);

    // Reset during refill beat 4
    mem_chk = 1'b0;
    found   = 1'b0;
    @(posedge clk);
    #1;
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 32'h140;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (mem_req && mem_addr == 32'h150) found = 1'b1;
    end
    check("rr_reach_beat4", 32'(found), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rr_mem_req", 32'(mem_req), 32'h0);
    check("rr_valid", 32'(valid), 32'h0);
    check("rr_dirty", 32'(dirty), 32'h0);
    check("rr_cache0_w2", cache0[95:64], 32'h0);
    cpu_req = 1'b0;
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    mem_chk = 1'b1;
    push_refill(32'h140);
    cpu_access(1'b0, 32'h140, 32'h0, 32'h300, 10, "lat_rerefill");
    check("rr2_valid", 32'(valid), 32'h4);
    check("rr2_cache2_w4", cache2[159:128], 32'h304);

    repeat (3) @(posedge clk);
    check("mem_q_drained", 32'(mem_q.size()), 32'h0);
    check("cpu_q_drained", 32'(cpu_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
